// File: rtl/id_pkg.sv
// Shared decode definitions for the registered ID stage: opcode/funct codes,
// the ALU operation enum, the immediate-extension select and the control bundle.
package id_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   localparam int ALUOP_W = 4;

   typedef enum logic [ALUOP_W-1:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI, ALU_NOP
   } alu_op_t;

   typedef enum logic [1:0] {IMM_SIGN, IMM_ZERO, IMM_LUI} imm_sel_t;

   typedef struct packed {
      logic    reg_write;
      logic    reg_dst;
      logic    alu_src;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      alu_op_t alu_op;
      logic    branch;
      logic    jump;
   } ctrl_t;

endpackage

// File: rtl/id_ctrl_dec.sv
// Combinational opcode/funct decoder producing the control bundle, the illegal
// flag and the immediate-extension select.
module id_ctrl_dec
   import id_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output ctrl_t      ctrl,
   output logic       illegal,
   output imm_sel_t   imm_sel
);

   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      imm_sel = IMM_SIGN;
      case (opcode)
         OP_RTYPE: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
            case (funct)
               FN_ADDU: ctrl.alu_op = ALU_ADD;
               FN_SUBU: ctrl.alu_op = ALU_SUB;
               FN_AND:  ctrl.alu_op = ALU_AND;
               FN_OR:   ctrl.alu_op = ALU_OR;
               FN_XOR:  ctrl.alu_op = ALU_XOR;
               FN_SLT:  ctrl.alu_op = ALU_SLT;
               FN_SLL:  ctrl.alu_op = ALU_SLL;
               FN_SRL:  ctrl.alu_op = ALU_SRL;
               FN_JR: begin
                  ctrl.reg_write = 1'b0;
                  ctrl.reg_dst   = 1'b0;
                  ctrl.jump      = 1'b1;
                  ctrl.alu_op    = ALU_NOP;
               end
               default: begin
                  ctrl    = '0;
                  illegal = 1'b1;
               end
            endcase
         end
         OP_ADDIU: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         OP_ANDI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_AND;
            imm_sel        = IMM_ZERO;
         end
         OP_ORI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_OR;
            imm_sel        = IMM_ZERO;
         end
         OP_LUI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_LUI;
            imm_sel        = IMM_LUI;
         end
         OP_LW: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.alu_op     = ALU_ADD;
         end
         OP_SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         OP_BEQ, OP_BNE: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALU_SUB;
         end
         OP_J: begin
            ctrl.jump   = 1'b1;
            ctrl.alu_op = ALU_NOP;
         end
         OP_JAL: begin
            ctrl.jump      = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_NOP;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered MIPS decode stage with valid/ready on both sides, load-use bubble
// insertion, flush and a saturating bubble counter.
module id_stage_pipe
   import id_pkg::*;
#(
   parameter int PC_W      = 32,
   parameter bit HAZARD_EN = 1'b1,
   parameter int CNT_W     = 16
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_inst,
   input  logic [PC_W-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [4:0]         out_rs,
   output logic [4:0]         out_rt,
   output logic [4:0]         out_rd,
   output logic [4:0]         out_shamt,
   output logic [4:0]         out_wreg,
   output logic [31:0]        out_imm_ext,
   output logic [25:0]        out_instr_index,
   output logic               out_reg_write,
   output logic               out_reg_dst,
   output logic               out_alu_src,
   output logic               out_mem_read,
   output logic               out_mem_write,
   output logic               out_mem_to_reg,
   output logic [ALUOP_W-1:0] out_alu_op,
   output logic               out_branch,
   output logic               out_jump,
   output logic               out_illegal,
   output logic [CNT_W-1:0]   stall_cnt
);

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, wreg;
   logic [31:0] imm_ext;
   ctrl_t       dec_ctrl, q_ctrl;
   logic        dec_illegal;
   imm_sel_t    dec_imm_sel;
   logic        hazard, advance;

   assign opcode = in_inst[31:26];
   assign funct  = in_inst[5:0];
   assign rs     = in_inst[25:21];
   assign rt     = in_inst[20:16];
   assign rd     = in_inst[15:11];

   id_ctrl_dec u_ctrl_dec (
      .opcode  (opcode),
      .funct   (funct),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal),
      .imm_sel (dec_imm_sel)
   );

   always_comb begin
      case (dec_imm_sel)
         IMM_ZERO: imm_ext = {16'h0000, in_inst[15:0]};
         IMM_LUI:  imm_ext = {in_inst[15:0], 16'h0000};
         default:  imm_ext = {{16{in_inst[15]}}, in_inst[15:0]};
      endcase
   end

   assign wreg = (opcode == OP_JAL) ? 5'd31 : (dec_ctrl.reg_dst ? rd : rt);

   // Load-use check: the held bundle is a load whose target the incoming word reads.
   generate
      if (HAZARD_EN) begin : g_hazard
         logic uses_rt;
         assign uses_rt = ((opcode == OP_RTYPE) && (funct != FN_JR)) ||
                          (opcode == OP_SW) || (opcode == OP_BEQ) || (opcode == OP_BNE);
         assign hazard  = out_valid && q_ctrl.mem_read && (out_rt != 5'd0) &&
                          ((rs == out_rt) || (uses_rt && (rt == out_rt)));
      end else begin : g_no_hazard
         assign hazard = 1'b0;
      end
   endgenerate

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && !hazard;

   // Flush beats bubble beats load; otherwise the bundle holds under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid       <= 1'b0;
         out_pc          <= '0;
         out_rs          <= '0;
         out_rt          <= '0;
         out_rd          <= '0;
         out_shamt       <= '0;
         out_wreg        <= '0;
         out_imm_ext     <= '0;
         out_instr_index <= '0;
         q_ctrl          <= '0;
         out_illegal     <= 1'b0;
         stall_cnt       <= '0;
      end else if (flush) begin
         out_valid   <= 1'b0;
         q_ctrl      <= '0;
         out_illegal <= 1'b0;
      end else if (advance && hazard && in_valid) begin
         out_valid   <= 1'b0;
         q_ctrl      <= '0;
         out_illegal <= 1'b0;
         if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end else if (advance) begin
         out_valid       <= in_valid;
         out_pc          <= in_pc;
         out_rs          <= rs;
         out_rt          <= rt;
         out_rd          <= rd;
         out_shamt       <= in_inst[10:6];
         out_wreg        <= wreg;
         out_imm_ext     <= imm_ext;
         out_instr_index <= in_inst[25:0];
         q_ctrl          <= in_valid ? dec_ctrl : '0;
         out_illegal     <= in_valid && dec_illegal;
      end
   end

   assign out_reg_write  = q_ctrl.reg_write;
   assign out_reg_dst    = q_ctrl.reg_dst;
   assign out_alu_src    = q_ctrl.alu_src;
   assign out_mem_read   = q_ctrl.mem_read;
   assign out_mem_write  = q_ctrl.mem_write;
   assign out_mem_to_reg = q_ctrl.mem_to_reg;
   assign out_alu_op     = q_ctrl.alu_op;
   assign out_branch     = q_ctrl.branch;
   assign out_jump       = q_ctrl.jump;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: a hazard-enabled instance (narrow counter) and a
// hazard-disabled instance share stimulus and are compared to an instruction-level model.
module tb_id_stage_pipe;
   import id_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        out_ready;

   logic               ov[2], ir[2];
   logic [31:0]        opc[2], oimm[2];
   logic [4:0]         ors[2], ort[2], ord[2], osh[2], owr[2];
   logic [25:0]        oidx[2];
   logic               orw[2], ordst[2], oasrc[2], omr[2], omw[2], om2r[2];
   logic [ALUOP_W-1:0] oaop[2];
   logic               obr[2], ojmp[2], oill[2];
   logic [3:0]         cnt0;
   logic [15:0]        cnt1;

   int checks = 0;
   int errors = 0;

   typedef enum {K_ADDU, K_SUBU, K_AND, K_OR, K_XOR, K_SLT, K_SLL, K_SRL, K_JR,
                 K_ADDIU, K_ANDI, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE,
                 K_J, K_JAL, K_ILL} kind_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs, rt, rd, shamt, wreg;
      logic [31:0] imm;
      logic        imm_def;
      logic [25:0] idx;
      logic        rw, rdst, asrc, mr, mw, m2r;
      logic [3:0]  aop;
      logic        br, jmp, ill;
   } bundle_t;

   bit      m_valid[2];
   bundle_t m_b[2];
   int      m_cnt[2];
   int      cnt_max[2] = '{15, 65535};
   bit      hz_en[2]   = '{1'b1, 1'b0};

   always #5 clk = ~clk;

   id_stage_pipe #(.PC_W(32), .HAZARD_EN(1'b1), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov[0]), .out_ready(out_ready),
      .out_pc(opc[0]), .out_rs(ors[0]), .out_rt(ort[0]), .out_rd(ord[0]), .out_shamt(osh[0]),
      .out_wreg(owr[0]), .out_imm_ext(oimm[0]), .out_instr_index(oidx[0]),
      .out_reg_write(orw[0]), .out_reg_dst(ordst[0]), .out_alu_src(oasrc[0]),
      .out_mem_read(omr[0]), .out_mem_write(omw[0]), .out_mem_to_reg(om2r[0]),
      .out_alu_op(oaop[0]), .out_branch(obr[0]), .out_jump(ojmp[0]),
      .out_illegal(oill[0]), .stall_cnt(cnt0)
   );

   id_stage_pipe #(.PC_W(32), .HAZARD_EN(1'b0), .CNT_W(16)) dut_nh (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov[1]), .out_ready(out_ready),
      .out_pc(opc[1]), .out_rs(ors[1]), .out_rt(ort[1]), .out_rd(ord[1]), .out_shamt(osh[1]),
      .out_wreg(owr[1]), .out_imm_ext(oimm[1]), .out_instr_index(oidx[1]),
      .out_reg_write(orw[1]), .out_reg_dst(ordst[1]), .out_alu_src(oasrc[1]),
      .out_mem_read(omr[1]), .out_mem_write(omw[1]), .out_mem_to_reg(om2r[1]),
      .out_alu_op(oaop[1]), .out_branch(obr[1]), .out_jump(ojmp[1]),
      .out_illegal(oill[1]), .stall_cnt(cnt1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic kind_t classify(input logic [31:0] w);
      case (w[31:26])
         6'h00: case (w[5:0])
            6'h21: return K_ADDU;
            6'h23: return K_SUBU;
            6'h24: return K_AND;
            6'h25: return K_OR;
            6'h26: return K_XOR;
            6'h2A: return K_SLT;
            6'h00: return K_SLL;
            6'h02: return K_SRL;
            6'h08: return K_JR;
            default: return K_ILL;
         endcase
         6'h09: return K_ADDIU;
         6'h0C: return K_ANDI;
         6'h0D: return K_ORI;
         6'h0F: return K_LUI;
         6'h23: return K_LW;
         6'h2B: return K_SW;
         6'h04: return K_BEQ;
         6'h05: return K_BNE;
         6'h02: return K_J;
         6'h03: return K_JAL;
         default: return K_ILL;
      endcase
   endfunction

   function automatic bundle_t expectBundle(input logic [31:0] w, input logic [31:0] pc);
      bundle_t b;
      kind_t   k;
      bit      ralu;
      k    = classify(w);
      ralu = k inside {K_ADDU, K_SUBU, K_AND, K_OR, K_XOR, K_SLT, K_SLL, K_SRL};
      b       = '0;
      b.pc    = pc;
      b.rs    = w[25:21];
      b.rt    = w[20:16];
      b.rd    = w[15:11];
      b.shamt = w[10:6];
      b.idx   = w[25:0];
      b.rw    = ralu || (k inside {K_ADDIU, K_ANDI, K_ORI, K_LUI, K_LW, K_JAL});
      b.rdst  = ralu;
      b.asrc  = k inside {K_ADDIU, K_ANDI, K_ORI, K_LUI, K_LW, K_SW};
      b.mr    = (k == K_LW);
      b.m2r   = (k == K_LW);
      b.mw    = (k == K_SW);
      b.br    = k inside {K_BEQ, K_BNE};
      b.jmp   = k inside {K_J, K_JAL, K_JR};
      b.ill   = (k == K_ILL);
      b.wreg  = (k == K_JAL) ? 5'd31 : (b.rdst ? b.rd : b.rt);
      if (k inside {K_ADDIU, K_LW, K_SW, K_BEQ, K_BNE}) begin
         b.imm = {{16{w[15]}}, w[15:0]};  b.imm_def = 1'b1;
      end else if (k inside {K_ANDI, K_ORI}) begin
         b.imm = {16'h0000, w[15:0]};     b.imm_def = 1'b1;
      end else if (k == K_LUI) begin
         b.imm = {w[15:0], 16'h0000};     b.imm_def = 1'b1;
      end
      case (k)
         K_ADDU, K_ADDIU, K_LW, K_SW: b.aop = ALU_ADD;
         K_SUBU, K_BEQ, K_BNE:        b.aop = ALU_SUB;
         K_AND, K_ANDI:               b.aop = ALU_AND;
         K_OR, K_ORI:                 b.aop = ALU_OR;
         K_XOR:                       b.aop = ALU_XOR;
         K_SLT:                       b.aop = ALU_SLT;
         K_SLL:                       b.aop = ALU_SLL;
         K_SRL:                       b.aop = ALU_SRL;
         K_LUI:                       b.aop = ALU_LUI;
         K_J, K_JAL, K_JR:            b.aop = ALU_NOP;
         default:                     b.aop = 4'd0;
      endcase
      return b;
   endfunction

   function automatic bit hazardOf(input int d, input logic [31:0] w);
      kind_t k;
      bit    reads_rt;
      k = classify(w);
      reads_rt = ((w[31:26] == 6'h00) && (k != K_JR)) || (k inside {K_SW, K_BEQ, K_BNE});
      if (!hz_en[d]) return 1'b0;
      return m_valid[d] && m_b[d].mr && (m_b[d].rt != 5'd0) &&
             ((w[25:21] == m_b[d].rt) || (reads_rt && (w[20:16] == m_b[d].rt)));
   endfunction

   function automatic logic [31:0] randInst();
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] imm;
      logic [25:0] idx;
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 31));
      sh  = 5'($urandom_range(0, 31));
      imm = 16'($urandom());
      idx = 26'($urandom());
      case ($urandom_range(0, 22))
         0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
         1:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
         2:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
         3:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
         4:  return {6'h00, rs, rt, rd, 5'd0, 6'h26};
         5:  return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
         6:  return {6'h00, 5'd0, rt, rd, sh, 6'h00};
         7:  return {6'h00, 5'd0, rt, rd, sh, 6'h02};
         8:  return {6'h00, rs, 15'd0, 6'h08};
         9:  return {6'h09, rs, rt, imm};
         10: return {6'h0C, rs, rt, imm};
         11: return {6'h0D, rs, rt, imm};
         12: return {6'h0F, 5'd0, rt, imm};
         13, 14, 15: return {6'h23, rs, rt, imm};
         16: return {6'h2B, rs, rt, imm};
         17: return {6'h04, rs, rt, imm};
         18: return {6'h05, rs, rt, imm};
         19: return {6'h02, idx};
         20: return {6'h03, idx};
         21: return {6'h3F, idx};
         default: return {6'h00, rs, rt, rd, sh, 6'h3F};
      endcase
   endfunction

   task automatic checkState();
      for (int d = 0; d < 2; d++) begin
         string s;
         s = (d == 0) ? "" : "_nh";
         checkOutput({"out_valid", s}, 32'(ov[d]), 32'(m_valid[d]));
         checkOutput({"stall_cnt", s}, (d == 0) ? 32'(cnt0) : 32'(cnt1), 32'(m_cnt[d]));
         if (m_valid[d]) begin
            checkOutput({"pc", s}, opc[d], m_b[d].pc);
            checkOutput({"rs", s}, 32'(ors[d]), 32'(m_b[d].rs));
            checkOutput({"rt", s}, 32'(ort[d]), 32'(m_b[d].rt));
            checkOutput({"rd", s}, 32'(ord[d]), 32'(m_b[d].rd));
            checkOutput({"shamt", s}, 32'(osh[d]), 32'(m_b[d].shamt));
            checkOutput({"wreg", s}, 32'(owr[d]), 32'(m_b[d].wreg));
            checkOutput({"index", s}, 32'(oidx[d]), 32'(m_b[d].idx));
            if (m_b[d].imm_def) checkOutput({"imm", s}, oimm[d], m_b[d].imm);
            checkOutput({"ctrl", s},
                        32'({orw[d], ordst[d], oasrc[d], omr[d], omw[d], om2r[d], obr[d], ojmp[d], oill[d]}),
                        32'({m_b[d].rw, m_b[d].rdst, m_b[d].asrc, m_b[d].mr, m_b[d].mw,
                             m_b[d].m2r, m_b[d].br, m_b[d].jmp, m_b[d].ill}));
            checkOutput({"alu_op", s}, 32'(oaop[d]), 32'(m_b[d].aop));
         end
      end
   endtask

   // One clock of stimulus: drive at negedge, check in_ready, step model at posedge, check outputs.
   task automatic applyStimulus(input bit iv, input logic [31:0] inst, input logic [31:0] pc,
                                input bit ordy, input bit fl);
      bit adv[2], hz[2];
      @(negedge clk);
      in_valid  = iv;
      in_inst   = inst;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      #1;
      for (int d = 0; d < 2; d++) begin
         adv[d] = !m_valid[d] || ordy;
         hz[d]  = hazardOf(d, inst);
         checkOutput((d == 0) ? "in_ready" : "in_ready_nh", 32'(ir[d]), 32'(adv[d] && !hz[d]));
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (fl) begin
            m_valid[d] = 1'b0;
         end else if (adv[d] && hz[d] && iv) begin
            m_valid[d] = 1'b0;
            if (m_cnt[d] < cnt_max[d]) m_cnt[d]++;
         end else if (adv[d]) begin
            m_valid[d] = iv;
            if (iv) m_b[d] = expectBundle(inst, pc);
         end
      end
      #1;
      checkState();
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_out_valid", 32'(ov[0]), 0);
      checkOutput("rst_stall_cnt", 32'(cnt0), 0);
      checkOutput("rst_in_ready", 32'(ir[0]), 1);
      checkOutput("rst_fields", {27'd0, ors[0]} | {27'd0, owr[0]} | oimm[0] | opc[0], 0);
      checkOutput("rst_ctrl", 32'({orw[0], omr[0], oaop[0], oill[0], ojmp[0]}), 0);
      rst_n = 1'b1;

      applyStimulus(1, 32'h00221821, 32'h100, 1, 0);
      checkOutput("addu_valid", 32'(ov[0]), 1);
      checkOutput("addu_rs", 32'(ors[0]), 1);
      checkOutput("addu_rt", 32'(ort[0]), 2);
      checkOutput("addu_wreg", 32'(owr[0]), 3);
      checkOutput("addu_rw_rdst", 32'({orw[0], ordst[0], oill[0]}), 32'b110);
      checkOutput("addu_alu", 32'(oaop[0]), 32'(ALU_ADD));

      applyStimulus(1, 32'h2422FFFF, 32'h104, 1, 0);
      checkOutput("addiu_imm", oimm[0], 32'hFFFFFFFF);
      applyStimulus(1, 32'h3422FFFF, 32'h108, 1, 0);
      checkOutput("ori_imm", oimm[0], 32'h0000FFFF);

      applyStimulus(1, 32'h8C220004, 32'h10C, 1, 0);
      applyStimulus(1, 32'h00411821, 32'h110, 1, 0);
      checkOutput("bubble_valid", 32'(ov[0]), 0);
      checkOutput("bubble_cnt", 32'(cnt0), 1);
      checkOutput("nohz_valid", 32'(ov[1]), 1);
      applyStimulus(1, 32'h00411821, 32'h110, 1, 0);
      checkOutput("dep_pc", opc[0], 32'h110);
      checkOutput("nohz_cnt", 32'(cnt1), 0);

      applyStimulus(1, 32'h00221823, 32'h200, 1, 0);
      repeat (3) applyStimulus(1, 32'h00221824, 32'h204, 0, 0);
      checkOutput("bp_hold_pc", opc[0], 32'h200);
      applyStimulus(1, 32'h00221824, 32'h204, 1, 0);
      checkOutput("bp_next_pc", opc[0], 32'h204);

      applyStimulus(1, 32'h00221825, 32'h300, 0, 1);
      checkOutput("flush_valid", 32'(ov[0]), 0);
      applyStimulus(1, 32'h00221826, 32'h304, 1, 0);
      checkOutput("post_flush_pc", opc[0], 32'h304);

      applyStimulus(1, 32'hFC000000, 32'h308, 1, 0);
      checkOutput("illegal", 32'(oill[0]), 1);
      checkOutput("illegal_ctrl", 32'({orw[0], omr[0], omw[0], obr[0], ojmp[0], oaop[0]}), 0);

      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom_range(0, 9) < 8), randInst(), $urandom(),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      end

      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(ov[0]), 0);
      checkOutput("midrst_cnt", 32'(cnt0), 0);
      checkOutput("midrst_valid_nh", 32'(ov[1]), 0);
      for (int d = 0; d < 2; d++) begin
         m_valid[d] = 1'b0;
         m_cnt[d]   = 0;
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom_range(0, 9) < 8), randInst(), $urandom(),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered, parametrised MIPS instruction-decode stage; the sequential successor to the combinational ID decode.
- Accepts fetched instructions on a valid/ready handshake and splits the fields.
- Generates datapath control and extended immediates, detects load-use hazards, and inserts a bubble for each one.
- Presents one registered decode bundle to EX over valid/ready; supports flush and keeps a saturating stall counter.

Parameters:
- PC_W, 32, width of the pc passed alongside the instruction
- HAZARD_EN, 1, 1 = load-use detection active; 0 = detection removed, in_ready is purely handshake-driven
- CNT_W, 16, width of the stall counter (saturating)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of the stage contents (branch/exception)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  PC_W  instruction address
- out_valid  out  1  decode bundle valid
- out_ready  in  1  EX accepts the bundle
- out_pc  out  PC_W  registered pc
- out_rs, out_rt, out_rd, out_shamt  out  5 each  register fields
- out_wreg  out  5  destination: rd if RegDst, 31 for JAL, else rt
- out_imm_ext  out  32  sign-extended imm (ADDIU, LW, SW, BEQ, BNE); zero-extended (ANDI, ORI); imm<<16 (LUI)
- out_instr_index  out  26  jump target field
- out_reg_write, out_reg_dst, out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg  out  1 each  control
- out_alu_op  out  ALUOP_W  ALU operation code (package enum)
- out_branch, out_jump  out  1 each  branch class / J, JAL, JR
- out_illegal  out  1  unsupported opcode/funct; all other control forced 0
- stall_cnt  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset: out_valid = 0, all out_* fields and control = 0, stall_cnt = 0. in_ready is combinational and reads 1 while out_valid = 0.
- Supported instructions:
  - R-type: ADDU, SUBU, AND, OR, XOR, SLT, SLL, SRL, JR
  - I/J-type: ADDIU, ANDI, ORI, LUI, LW, SW, BEQ, BNE, J, JAL
  - Anything else raises out_illegal.
- Latency: 1 cycle. When an input beat is accepted at edge N, its bundle is valid from edge N+1.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance && !hazard.
  - A transfer occurs when in_valid && in_ready.
  - Bundle fields stay stable while out_valid && !out_ready.
- Register update at each edge, in priority order:
  - flush: out_valid <= 0, and this cycle's input beat is discarded.
  - else if advance && hazard && in_valid: out_valid <= 0 (bubble, fields don't-care, control 0), stall_cnt += 1 (saturates at all-ones).
  - else if advance: out_valid <= in_valid, and the bundle loads from the decoder.
  - else: hold.
- flush: in_ready still follows the formula; an accepted beat is dropped, not decoded.
- Hazard (HAZARD_EN = 1): out_valid && out_mem_read && out_rt != 0 && (in rs == out_rt || (in uses rt as a source && in rt == out_rt)).
  - "Uses rt as a source" means R-type except JR, plus SW, BEQ, BNE.
  - Each hazard produces exactly one bubble; the next cycle the load has left the stage and the dependant is accepted.
- A hazard together with !out_ready is a plain stall with no bubble and no count.
- stall_cnt is 0 and unchanged whenever HAZARD_EN = 0.
- Reset asserted mid-transfer clears the stage immediately (asynchronously); no partial bundle remains.

Decomposition:
- Package id_pkg holds:
  - opcode/funct localparams
  - ALUOP_W and the alu_op enum (ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, LUI, NOP)
  - a packed struct for the control bundle
- Sub-module id_ctrl_dec: purely combinational op/funct -> control struct + illegal + imm-extension select; instantiated once.

Test Plan:
- ADDU $3,$1,$2 (0x00221821), out_ready = 1 -> next cycle out_valid = 1, rs = 1, rt = 2, wreg = 3, reg_write = 1, reg_dst = 1, alu_op = ADD, illegal = 0.
- ADDIU 0x2422FFFF then ORI 0x3422FFFF back-to-back -> imm_ext = 0xFFFFFFFF then 0x0000FFFF; one bundle per cycle, in_ready constantly 1.
- LW 0x8C220004 followed by ADDU 0x00411821 (rs = $2) -> one bubble cycle (out_valid = 0, in_ready = 0), ADDU emitted the cycle after, stall_cnt = 1. Repeat with HAZARD_EN = 0 -> no bubble, stall_cnt = 0.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, bundle stable, no beats lost; the next instruction appears 1 cycle after out_ready rises.
- Flush asserted with a valid bundle held and in_valid = 1 -> next cycle out_valid = 0, the incoming beat is dropped, and the following instruction decodes normally.
- 0xFC000000 -> out_illegal = 1, all control 0. Assert rst_n = 0 mid-stream -> out_valid and stall_cnt are 0 before the next edge.
